// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit control codes, sequential-unit state encoding
// and the ALUOp encoding produced by the main decoder for the ALU controller.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_BNE  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_SRAV = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd13;
    localparam logic [3:0] ALU_LUI  = 4'd14;

    // ALUOp from the main decoder to the ALU controller
    localparam logic [1:0] ALUOP_MEM    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;
    localparam logic [1:0] ALUOP_IMM    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle ALU datapath: every legal code except MUL, which the
// sequential top handles. Unsupported codes give zero and flag illegal.
module seq_alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    // Decode the control code into a result
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_MUL:  result = '0;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_BNE:  result = a - b;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_SRAV: result = $signed(b) >>> a[SHW-1:0];
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:  result = b << (WIDTH/2);
            default: begin
                result  = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: registered single-cycle ops plus an iterative shift-add MUL.
// Build option SEQ_ALU_MUL_EARLY_EXIT_EN ends MUL once the multiplier runs out of ones.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o,
    output logic             done_o
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   count_r;
    logic [WIDTH-1:0] comb_res_s;
    logic             comb_ill_s;
    logic [WIDTH-1:0] mul_acc_s;
    logic [WIDTH-1:0] mplier_shift_s;
    logic             mul_last_s;
    logic             ready_s;
    logic             done_s;

    seq_alu_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .ctrl    (ctrl_i),
        .a       (src1_i),
        .b       (src2_i),
        .shamt   (shamt_i),
        .result  (comb_res_s),
        .illegal (comb_ill_s)
    );

    assign mul_acc_s      = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
    assign mplier_shift_s = mplier_r >> 1;
`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
    assign mul_last_s = (count_r == SHW'(WIDTH-1)) || (mplier_shift_s == {WIDTH{1'b0}});
`else
    assign mul_last_s = (count_r == SHW'(WIDTH-1));
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE accepts a new request just like IDLE
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_nxt_s = (ctrl_i == ALU_MUL) ? S_MUL : S_DONE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_MUL;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        ready_s = 1'b1;
        done_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                ready_s = 1'b1;
                done_s  = 1'b0;
            end
            S_MUL: begin
                ready_s = 1'b0;
                done_s  = 1'b0;
            end
            S_DONE: begin
                ready_s = 1'b1;
                done_s  = 1'b1;
            end
            default: begin
                ready_s = 1'b1;
                done_s  = 1'b0;
            end
        endcase
    end

    assign ready_o = ready_s;
    assign done_o  = done_s;

    // Operand capture, shift-add iteration and result/flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_r   <= '0;
            mplier_r  <= '0;
            acc_r     <= '0;
            count_r   <= '0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else if (state_r == S_MUL) begin
            acc_r    <= mul_acc_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_shift_s;
            count_r  <= count_r + SHW'(1);
            if (mul_last_s) begin
                result_o  <= mul_acc_s;
                zero_o    <= (mul_acc_s == {WIDTH{1'b0}});
                illegal_o <= 1'b0;
            end
        end else if (start_i) begin
            if (ctrl_i == ALU_MUL) begin
                mcand_r  <= src1_i;
                mplier_r <= src2_i;
                acc_r    <= '0;
                count_r  <= '0;
            end else begin
                result_o  <= comb_res_s;
                illegal_o <= comb_ill_s;
                // BNE reports "taken" on zero_o, so its sense is inverted
                zero_o    <= (ctrl_i == ALU_BNE) ? (comb_res_s != {WIDTH{1'b0}})
                                                 : (comb_res_s == {WIDTH{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a behavioural model.
// Honours SEQ_ALU_MUL_EARLY_EXIT_EN for expected MUL latency.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready;
    logic [3:0]  ctrl = 4'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ready_o   (ready),
        .ctrl_i    (ctrl),
        .src1_i    (src1),
        .src2_i    (src2),
        .shamt_i   (shamt),
        .result_o  (result),
        .zero_o    (zero),
        .illegal_o (illegal),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {illegal, zero, result} from the instruction-set definition
    function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      q;
        logic [63:0] p;
        logic [31:0] r;
        logic        ill = 1'b0;
        logic        z;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            4'd6:  r = a - b;
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = a - b;
            4'd9:  begin q = sb >>> sh; r = q[31:0]; end
            4'd11: begin q = sb >>> a[4:0]; r = q[31:0]; end
            4'd13: r = (a < b) ? 32'd1 : 32'd0;
            4'd14: r = {b[15:0], 16'd0};
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        z = ill ? 1'b1 : ((c == 4'd8) ? (r != 32'd0) : (r == 32'd0));
        return {ill, z, r};
    endfunction

    function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
        int hb = -1;
        if (c != 4'd3) return 1;
`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
        for (int i = 0; i < 32; i++) if (b[i]) hb = i;
        return (hb < 0) ? 2 : 2 + hb;
`else
        hb = 0;
        return 33 + hb;
`endif
    endfunction

    // Issue one op from IDLE (caller is #1 after a posedge), wait for done, check all
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit hold);
        logic [33:0] e;
        int lat;
        e = model(c, a, b, sh);
        ctrl = c; src1 = a; src2 = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        // scramble inputs after acceptance; they must be ignored
        ctrl = 4'($urandom_range(0, 15)); src1 = $urandom; src2 = $urandom; shamt = 5'($urandom);
        start = hold;
        if (c == 4'd3 && !done) chk("busy_ready", 64'(ready), 64'd0);
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk($sformatf("lat_c%0d", c), 64'(lat), 64'(exp_lat(c, b)));
        chk($sformatf("res_c%0d", c), 64'(result), 64'(e[31:0]));
        chk($sformatf("zero_c%0d", c), 64'(zero), 64'(e[32]));
        chk($sformatf("ill_c%0d", c), 64'(illegal), 64'(e[33]));
        chk("done_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        int pulses;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ill", 64'(illegal), 64'd0);
        #13 rst = 1'b0;
        @(posedge clk); #1;

        do_op(4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk("add_wrap", 64'(result), 64'd0);
        chk("add_wrap_z", 64'(zero), 64'd1);
        do_op(4'd6, 32'd5, 32'd7, 5'd0, 1'b0);
        chk("sub", 64'(result), 64'hFFFF_FFFE);
        do_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk("slt", 64'(result), 64'd1);
        do_op(4'd13, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk("sltu", 64'(result), 64'd0);
        do_op(4'd3, 32'h0001_0000, 32'h0001_0001, 5'd0, 1'b1);
        chk("mul_big", 64'(result), 64'h0001_0000);
        do_op(4'd3, 32'd7, 32'd3, 5'd0, 1'b0);
        chk("mul_7x3", 64'(result), 64'd21);
        do_op(4'd3, 32'd12345, 32'd0, 5'd0, 1'b0);
        chk("mul_b0_z", 64'(zero), 64'd1);
        do_op(4'd9, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
        chk("sra", 64'(result), 64'hF800_0000);
        do_op(4'd11, 32'h24, 32'h8000_0000, 5'd0, 1'b0);
        chk("srav", 64'(result), 64'hF800_0000);
        do_op(4'd14, 32'd0, 32'h1234, 5'd0, 1'b0);
        chk("lui", 64'(result), 64'h1234_0000);
        do_op(4'd8, 32'd9, 32'd9, 5'd0, 1'b0);
        chk("bne_eq", 64'(zero), 64'd0);
        do_op(4'd8, 32'd9, 32'd8, 5'd0, 1'b0);
        chk("bne_ne", 64'(zero), 64'd1);
        do_op(4'd5, 32'd77, 32'd3, 5'd0, 1'b0);
        chk("illegal", 64'(illegal), 64'd1);
        chk("illegal_res", 64'(result), 64'd0);

        // Back-to-back: OR accepted in the ADD's DONE cycle
        ctrl = 4'd2; src1 = 32'd10; src2 = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_res1", 64'(result), 64'd30);
        ctrl = 4'd1; src1 = 32'hF0; src2 = 32'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done2", 64'(done), 64'd1);
        chk("b2b_res2", 64'(result), 64'hFF);
        @(posedge clk); #1;
        chk("b2b_idle", 64'(done), 64'd0);

        // Randomized ops, operands occasionally forced to edge values
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {32{a[0]}};
            if ($urandom_range(0, 3) == 0) b = (b[1]) ? 32'h8000_0000 : 32'(b[7:0]);
            do_op(4'($urandom_range(0, 15)), a, b, 5'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a multiply
        do_op(4'd2, 32'd100, 32'd23, 5'd0, 1'b0);
        ctrl = 4'd3; src1 = 32'd55; src2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(ready), 64'd1);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("mrst_nopulse", 64'(pulses), 64'd0);
        do_op(4'd2, 32'd3, 32'd4, 5'd0, 1'b0);
        chk("mrst_add", 64'(result), 64'd7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
